// File: rtl/uart_tx_fifo_if.sv
// Byte producer handshake into the UART transmitter: data_in is transferred on
// any rising edge where data_valid && data_ready.
interface uart_tx_fifo_if;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;

  modport master (output data_in, output data_valid, input data_ready);
  modport slave  (input data_in, input data_valid, output data_ready);
endinterface

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small byte FIFO; a byte pushed into an empty idle
// FIFO starts its start bit one clock later. data_ready drops only when the FIFO is full.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 8,
  parameter int FIFO_DEPTH   = 4,
  parameter int MSB_FIRST    = 1
) (
  input  logic                          clk,
  input  logic                          btn,
  uart_tx_fifo_if.slave                 bus,
  output logic                          uart_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [PW:0]   FULL      = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] baud, baud_nxt;
  logic [2:0]    bit_idx, bit_idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic          tx_nxt;
  logic          push, pop, baud_end;

  assign bus.data_ready = (fifo_count != FULL);
  assign push           = bus.data_valid && bus.data_ready;
  assign busy           = (state != IDLE) || (fifo_count != '0);
  assign baud_end       = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.data_in;
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + (PW+1)'(1);
        2'b01:   fifo_count <= fifo_count - (PW+1)'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge btn) begin
    if (!btn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shreg   <= '0;
      uart_tx <= 1'b1;
    end else begin
      state   <= state_nxt;
      baud    <= baud_nxt;
      bit_idx <= bit_idx_nxt;
      shreg   <= shreg_nxt;
      uart_tx <= tx_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    baud_nxt    = baud;
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    tx_nxt      = uart_tx;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (fifo_count != '0) begin
          pop       = 1'b1;
          shreg_nxt = mem[rd_ptr];
          baud_nxt  = '0;
          state_nxt = START;
          tx_nxt    = 1'b0;
        end
      end
      START: begin
        if (baud_end) begin
          baud_nxt    = '0;
          bit_idx_nxt = '0;
          state_nxt   = DATA;
          tx_nxt      = (MSB_FIRST != 0) ? shreg[7] : shreg[0];
        end else begin
          baud_nxt = baud + CW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (bit_idx == 3'd7) begin
            state_nxt = STOP;
            tx_nxt    = 1'b1;
          end else begin
            // The line always shows the bit at the outgoing end of the shifter.
            bit_idx_nxt = bit_idx + 3'd1;
            if (MSB_FIRST != 0) begin
              shreg_nxt = {shreg[6:0], 1'b0};
              tx_nxt    = shreg[6];
            end else begin
              shreg_nxt = {1'b0, shreg[7:1]};
              tx_nxt    = shreg[1];
            end
          end
        end else begin
          baud_nxt = baud + CW'(1);
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_nxt = '0;
          if (fifo_count != '0) begin
            pop       = 1'b1;
            shreg_nxt = mem[rd_ptr];
            state_nxt = START;
            tx_nxt    = 1'b0;
          end else begin
            state_nxt = IDLE;
            tx_nxt    = 1'b1;
          end
        end else begin
          baud_nxt = baud + CW'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        tx_nxt    = 1'b1;
      end
    endcase
  end

endmodule
